// File: rtl/srt_fp32_result_packer_if.sv
// Handshake bundle for the FP32 SRT divider result packer: upstream quotient/exponent/flags in,
// packed FP32 word plus exception flags out.
interface srt_fp32_result_packer_if #(
   parameter int QW = 27,
   parameter int EW = 10
);
   logic          in_valid;
   logic          in_ready;
   logic [QW-1:0] q_in;
   logic [EW-1:0] exp_in;
   logic          sign_in;
   logic          rem_nz_in;
   logic          nan_in;
   logic          dz_in;
   logic          inf_in;
   logic          zero_in;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   result;
   logic [4:0]    flags;

   modport master (
      output in_valid, q_in, exp_in, sign_in, rem_nz_in, nan_in, dz_in, inf_in, zero_in, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, q_in, exp_in, sign_in, rem_nz_in, nan_in, dz_in, inf_in, zero_in, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/srt_fp32_result_packer.sv
// FP32 SRT divider result packer: 1-bit normalize, round, over/underflow and IEEE-754 packing in a
// two-stage elastic pipeline. Define FP32_DIV_RNE_EN for round-to-nearest-even, else truncation.
module srt_fp32_result_packer #(
   parameter int QW = 27,
   parameter int EW = 10
) (
   input logic                      clk,
   input logic                      rst,
   srt_fp32_result_packer_if.slave  bus
);

   typedef enum logic [2:0] {K_NUM, K_NAN, K_DZ, K_INF, K_ZERO, K_QERR} kind_t;

   localparam logic signed [EW:0] E_MAX  = (EW+1)'(255);
   localparam logic signed [EW:0] E_ZERO = '0;
   localparam logic signed [EW:0] E_ONE  = (EW+1)'(1);

   logic [QW-1:0]    q;
   logic signed [EW:0] e_ext;

   // stage 1 registers
   logic             s1_v;
   kind_t            s1_kind;
   logic [23:0]      s1_man;
   logic             s1_g;
   logic             s1_st;
   logic             s1_sign;
   logic signed [EW:0] s1_e;

   // stage 2 (output) registers
   logic             out_v;
   logic [31:0]      res_q;
   logic [4:0]       flg_q;

   logic             s1_adv;
   logic             s2_adv;

   kind_t            n_kind;
   logic [23:0]      n_man;
   logic             n_g;
   logic             n_st;
   logic signed [EW:0] n_e;

   logic             inc;
   logic [24:0]      sum;
   logic [23:0]      m_r;
   logic signed [EW:0] e_r;
   logic [31:0]      n_res;
   logic [4:0]       n_flg;

   assign q      = bus.q_in;
   assign e_ext  = {bus.exp_in[EW-1], bus.exp_in};

   assign s2_adv = ~out_v | bus.out_ready;
   assign s1_adv = ~s1_v | s2_adv;

   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = out_v;
   assign bus.result    = res_q;
   assign bus.flags     = flg_q;

   always_comb begin
      n_kind = K_NUM;
      n_man  = q[QW-1 -: 24];
      n_g    = q[QW-25];
      n_st   = (|q[QW-26:0]) | bus.rem_nz_in;
      n_e    = e_ext;
      if (!q[QW-1]) begin
         if (q[QW-2]) begin
            n_man = q[QW-2 -: 24];
            n_g   = q[QW-26];
            n_st  = (|q[QW-27:0]) | bus.rem_nz_in;
            n_e   = e_ext - E_ONE;
         end else begin
            n_kind = K_QERR;
         end
      end
      if (bus.nan_in)       n_kind = K_NAN;
      else if (bus.dz_in)   n_kind = K_DZ;
      else if (bus.inf_in)  n_kind = K_INF;
      else if (bus.zero_in) n_kind = K_ZERO;
   end

`ifdef FP32_DIV_RNE_EN
   assign inc = s1_g & (s1_st | s1_man[0]);
`else
   assign inc = 1'b0;
`endif

   assign sum = {1'b0, s1_man} + {24'b0, inc};

   always_comb begin
      m_r = sum[23:0];
      e_r = s1_e;
      // rounding carried 0xFFFFFF into 2.0: renormalize to 1.0 and bump the exponent
      if (sum[24]) begin
         m_r = 24'h800000;
         e_r = s1_e + E_ONE;
      end
   end

   always_comb begin
      n_res = 32'h0;
      n_flg = 5'b00000;
      case (s1_kind)
         K_NAN:  begin n_res = 32'h7FC00000;               n_flg = 5'b10000; end
         K_DZ:   begin n_res = {s1_sign, 8'hFF, 23'h0};    n_flg = 5'b01000; end
         K_INF:  begin n_res = {s1_sign, 8'hFF, 23'h0};    n_flg = 5'b00000; end
         K_ZERO: begin n_res = {s1_sign, 31'h0};           n_flg = 5'b00000; end
         K_QERR: begin n_res = {s1_sign, 31'h0};           n_flg = 5'b00001; end
         default: begin
            if (e_r >= E_MAX) begin
`ifdef FP32_DIV_RNE_EN
               n_res = {s1_sign, 8'hFF, 23'h0};
`else
               n_res = {s1_sign, 8'hFE, 23'h7FFFFF};
`endif
               n_flg = 5'b00101;
            end else if (e_r <= E_ZERO) begin
               n_res = {s1_sign, 31'h0};
               n_flg = 5'b00011;
            end else begin
               n_res = {s1_sign, e_r[7:0], m_r[22:0]};
               n_flg = {4'b0000, s1_g | s1_st};
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_v    <= 1'b0;
         s1_kind <= K_NUM;
         s1_man  <= '0;
         s1_g    <= 1'b0;
         s1_st   <= 1'b0;
         s1_sign <= 1'b0;
         s1_e    <= '0;
         out_v   <= 1'b0;
         res_q   <= '0;
         flg_q   <= '0;
      end else begin
         if (s1_adv) s1_v <= bus.in_valid;
         if (s1_adv && bus.in_valid) begin
            s1_kind <= n_kind;
            s1_man  <= n_man;
            s1_g    <= n_g;
            s1_st   <= n_st;
            s1_sign <= bus.sign_in;
            s1_e    <= n_e;
         end
         if (s2_adv) out_v <= s1_v;
         if (s2_adv && s1_v) begin
            res_q <= n_res;
            flg_q <= n_flg;
         end
      end
   end

endmodule

// File: tb/tb_srt_fp32_result_packer.sv
// Randomized scoreboard bench for srt_fp32_result_packer with directed literal cases; honours
// FP32_DIV_RNE_EN the same way the design does.
module tb_srt_fp32_result_packer;

   typedef struct {
      int q;
      int e;
      bit s;
      bit rnz;
      bit nan;
      bit dz;
      bit inf;
      bit zero;
   } item_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   srt_fp32_result_packer_if bus ();
   srt_fp32_result_packer dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk  = 0;
   int n_fail = 0;

   item_t       cur_item;
   logic [36:0] exp_q[$];
   bit          hold = 1'b0;
   logic [36:0] held;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic item_t mk(int q, int e, bit s, bit rnz, bit nan, bit dz, bit inf, bit zero);
      item_t it;
      it.q = q; it.e = e; it.s = s; it.rnz = rnz;
      it.nan = nan; it.dz = dz; it.inf = inf; it.zero = zero;
      return it;
   endfunction

   // Reference: value-level rounding of q * 2^(e-127) into FP32
   function automatic logic [36:0] model(item_t it);
      longint m, r, half;
      int k, ex;
      bit up, inx;
      if (it.nan)  return {32'h7FC00000, 5'b10000};
      if (it.dz)   return {it.s, 8'hFF, 23'h0, 5'b01000};
      if (it.inf)  return {it.s, 8'hFF, 23'h0, 5'b00000};
      if (it.zero) return {it.s, 31'h0, 5'b00000};
      if (it.q < (1 << 25)) return {it.s, 31'h0, 5'b00001};
      k    = (it.q >= (1 << 26)) ? 3 : 2;
      ex   = (k == 3) ? it.e : it.e - 1;
      m    = longint'(it.q) >> k;
      r    = longint'(it.q) % (longint'(1) << k);
      half = longint'(1) << (k - 1);
      inx  = (r != 0) || it.rnz;
`ifdef FP32_DIV_RNE_EN
      up = (r > half) || (r == half && (it.rnz || (m % 2 == 1)));
`else
      up = 1'b0;
`endif
      m = m + longint'(up);
      if (m == (longint'(1) << 24)) begin
         m  = longint'(1) << 23;
         ex = ex + 1;
      end
      if (ex >= 255) begin
`ifdef FP32_DIV_RNE_EN
         return {it.s, 8'hFF, 23'h0, 5'b00101};
`else
         return {it.s, 8'hFE, 23'h7FFFFF, 5'b00101};
`endif
      end
      if (ex <= 0) return {it.s, 31'h0, 5'b00011};
      return {it.s, 8'(ex), 23'(m), 4'b0000, inx};
   endfunction

   task automatic apply(input item_t it, input bit v);
      cur_item      = it;
      bus.in_valid  = v;
      bus.q_in      = 27'(it.q);
      bus.exp_in    = 10'(it.e);
      bus.sign_in   = it.s;
      bus.rem_nz_in = it.rnz;
      bus.nan_in    = it.nan;
      bus.dz_in     = it.dz;
      bus.inf_in    = it.inf;
      bus.zero_in   = it.zero;
   endtask

   task automatic send(input item_t it);
      int t;
      apply(it, 1'b1);
      t = 0;
      @(negedge clk);
      while (!bus.in_ready && t < 50) begin
         @(posedge clk); #1;
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("send_timeout", 64'(t), 64'd0);
      @(posedge clk); #1;
      apply(it, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   function automatic item_t rand_item();
      item_t it;
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 5)       it.q = int'($urandom_range(0, (1 << 25) - 1));
      else if (r < 20) it.q = (1 << 27) - 1 - int'($urandom_range(0, 7));
      else if (r < 30) it.q = (1 << 26) - 1 - int'($urandom_range(0, 3));
      else             it.q = (1 << 25) + int'($urandom_range(0, (1 << 26) + (1 << 25) - 1));
      if ($urandom_range(0, 3) == 0) it.e = int'($urandom_range(0, 1023)) - 512;
      else                           it.e = int'($urandom_range(0, 265)) - 5;
      it.s    = 1'($urandom_range(0, 1));
      it.rnz  = 1'($urandom_range(0, 1));
      it.nan  = ($urandom_range(0, 19) == 0);
      it.dz   = ($urandom_range(0, 19) == 0);
      it.inf  = ($urandom_range(0, 19) == 0);
      it.zero = ($urandom_range(0, 19) == 0);
      return it;
   endfunction

   // Scoreboard: push on accept, compare on delivery, and require a stalled word to hold still
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         hold = 1'b0;
      end else begin
         if (hold) check("hold_stable", {31'b0, bus.out_valid, bus.result, bus.flags}, {31'b0, 1'b1, held});
         if (bus.in_valid && bus.in_ready) exp_q.push_back(model(cur_item));
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("sb_unexpected_output", 64'd1, 64'd0);
            else check("sb_result_flags", {27'b0, bus.result, bus.flags}, {27'b0, exp_q.pop_front()});
         end
         hold = bus.out_valid && !bus.out_ready;
         held = {bus.result, bus.flags};
      end
   end

   item_t t1, t2, t3a, t3b, t4, t5a, t5b;
   item_t bp[4];
   bit    pending;
   int    idx, streak;

   initial begin
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      bus.out_ready = 1'b1;

      t1  = mk(32'h6000000, 128, 0, 0, 0, 0, 0, 0);
      t2  = mk(32'h2AAAAAA, 126, 0, 1, 0, 0, 0, 0);
      t3a = mk(32'h7FFFFFF, 127, 0, 1, 0, 0, 0, 0);
      t3b = mk(32'h7FFFFFF, 300, 0, 1, 0, 0, 0, 0);
      t4  = mk(32'h4000000, 0,   1, 0, 0, 0, 0, 0);
      t5a = mk(32'h5555555, 140, 1, 0, 0, 1, 0, 0);
      t5b = mk(32'h5555555, 140, 0, 0, 1, 1, 0, 0);

      // hand-computed values that pin the model
      check("lit_t1", 64'(model(t1)), 64'({32'h40400000, 5'b00000}));
`ifdef FP32_DIV_RNE_EN
      check("lit_t2",  64'(model(t2)),  64'({32'h3EAAAAAB, 5'b00001}));
      check("lit_t3a", 64'(model(t3a)), 64'({32'h40000000, 5'b00001}));
      check("lit_t3b", 64'(model(t3b)), 64'({32'h7F800000, 5'b00101}));
`else
      check("lit_t2",  64'(model(t2)),  64'({32'h3EAAAAAA, 5'b00001}));
      check("lit_t3a", 64'(model(t3a)), 64'({32'h3FFFFFFF, 5'b00001}));
      check("lit_t3b", 64'(model(t3b)), 64'({32'h7F7FFFFF, 5'b00101}));
`endif
      check("lit_t4",  64'(model(t4)),  64'({32'h80000000, 5'b00011}));
      check("lit_t5a", 64'(model(t5a)), 64'({32'hFF800000, 5'b01000}));
      check("lit_t5b", 64'(model(t5b)), 64'({32'h7FC00000, 5'b10000}));

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_result",    64'(bus.result),    64'd0);
      check("rst_flags",     64'(bus.flags),     64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;

      // 6.0/2.0 with latency check
      send(t1);
      @(negedge clk);
      check("t1_not_early", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t1_valid_lat2", 64'(bus.out_valid), 64'd1);
      check("t1_result", 64'(bus.result), 64'h40400000);
      @(posedge clk); #1;

      send(t2); send(t3a); send(t3b); send(t4); send(t5a); send(t5b);
      idle(4);

      // backpressure: 4 back-to-back inputs, 6 stalled cycles
      for (int i = 0; i < 4; i++) bp[i] = mk(32'h4000000 + i * 32'h111111, 100 + i, i[0], 1, 0, 0, 0, 0);
      idx = 0;
      streak = 0;
      for (int cyc = 0; cyc < 11; cyc++) begin
         apply(bp[idx < 4 ? idx : 3], idx < 4);
         bus.out_ready = (cyc >= 6);
         @(negedge clk);
         if (cyc == 2) check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
         if (cyc == 5) check("bp_accepted_in_stall", 64'(idx), 64'd2);
         if (cyc >= 6 && cyc <= 9 && bus.out_valid) streak++;
         if (cyc == 10) check("bp_drained", 64'(bus.out_valid), 64'd0);
         if (bus.in_valid && bus.in_ready) idx++;
         @(posedge clk); #1;
      end
      apply(bp[3], 1'b0);
      check("bp_no_gap", 64'(streak), 64'd4);

      // reset while stalled discards in-flight results
      bus.out_ready = 1'b0;
      send(t2);
      send(t3a);
      idle(2);
      @(negedge clk);
      check("stall_full", 64'(bus.out_valid), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_mid_result", 64'(bus.result), 64'd0);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      idle(2);

      // randomized traffic with random backpressure
      pending = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!pending) apply(rand_item(), $urandom_range(0, 9) < 7);
         bus.out_ready = (cyc % 200 < 100) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
         @(negedge clk);
         pending = bus.in_valid && !bus.in_ready;
         @(posedge clk); #1;
      end
      apply(cur_item, 1'b0);
      bus.out_ready = 1'b1;
      idle(10);
      @(negedge clk);
      check("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
